// File: rtl/trans_pkg.sv
// Shared definitions for the transaction layer: word/counter widths, the
// status FSM encoding and the source-tagged word carried by the output buffer.
package trans_pkg;

  localparam int unsigned DW       = 6;  // data word width
  localparam int unsigned DEST_BIT = 4;  // word bit naming its destination FIFO
  localparam int unsigned CW       = 8;  // per-FIFO drain counter width

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
  } tagged_word_t;

endpackage

// File: rtl/trans_drain_arbiter_if.sv
// Bus bundle of the drain arbiter: FIFO read side (empty/pop/data per FIFO),
// merged valid/ready output stream, drain counters and status flags.
//   master : environment side (FIFOs + downstream sink)
//   slave  : arbiter side
interface trans_drain_arbiter_if;
  import trans_pkg::*;

  logic          empty_d0;
  logic          empty_d1;
  logic [DW-1:0] data_d0;
  logic [DW-1:0] data_d1;
  logic          pop_d0;
  logic          pop_d1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic          src_out;
  logic [CW-1:0] cnt_d0;
  logic [CW-1:0] cnt_d1;
  logic          active_out;
  logic          idle_out;
  logic          error_out;

  modport master (
    output empty_d0, empty_d1, data_d0, data_d1, ready_out,
    input  pop_d0, pop_d1, data_out, valid_out, src_out,
    input  cnt_d0, cnt_d1, active_out, idle_out, error_out
  );

  modport slave (
    input  empty_d0, empty_d1, data_d0, data_d1, ready_out,
    output pop_d0, pop_d1, data_out, valid_out, src_out,
    output cnt_d0, cnt_d1, active_out, idle_out, error_out
  );

endinterface

// File: rtl/out_buf2.sv
// Two-entry output FIFO with write-through: a word written while the FIFO is
// empty appears at the head in the same cycle, and leaves without being
// stored if it is also read that cycle.
//   clk, reset : clock, synchronous active-high reset
//   flush      : drops all stored entries
//   wr_en/wr_word : enqueue (caller guarantees space)
//   rd_en      : dequeue handshake (valid & ready)
//   valid_c/head_c : combinational head of the FIFO
//   count      : number of stored entries (registered)
module out_buf2
  import trans_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  tagged_word_t wr_word,
  input  logic         rd_en,
  output logic         valid_c,
  output tagged_word_t head_c,
  output logic [1:0]   count
);

  logic [1:0]   cnt_q, cnt_d;
  logic         rd_ptr_q, rd_ptr_d;
  tagged_word_t mem_q [2];
  tagged_word_t mem_d [2];

  logic empty_c;
  logic store_c;
  logic deq_c;
  logic wr_ptr_c;

  // Head selection with bypass of the incoming word when nothing is stored.
  always_comb begin
    empty_c  = (cnt_q == 2'd0);
    valid_c  = !empty_c || wr_en;
    head_c   = '0;
    if (!empty_c)  head_c = mem_q[rd_ptr_q];
    else if (wr_en) head_c = wr_word;
    deq_c    = rd_en && !empty_c;
    store_c  = wr_en && !(empty_c && rd_en);
    wr_ptr_c = rd_ptr_q ^ (cnt_q == 2'd1);
  end

  // Next storage state.
  always_comb begin
    for (int i = 0; i < 2; i++) mem_d[i] = mem_q[i];
    if (store_c) mem_d[wr_ptr_c] = wr_word;
    cnt_d    = cnt_q + 2'(store_c) - 2'(deq_c);
    rd_ptr_d = rd_ptr_q ^ deq_c;
    if (flush) begin
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/trans_drain_arbiter.sv
// Drains destination FIFOs D0/D1 round-robin into one valid/ready stream.
// Each popped word arrives the following cycle, is checked against its
// source FIFO via its destination bit, counted, and pushed into a 2-entry
// output buffer. Pops are credit-limited so no word is ever dropped.
//   clk   : clock
//   reset : synchronous active-high reset
//   init  : one-cycle pulse, flushes the block and (re)starts service
//   bus   : FIFO read side, merged output stream, counters, status flags
module trans_drain_arbiter (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  trans_drain_arbiter_if.slave  bus
);
  import trans_pkg::*;

  state_e        state_q, state_d;
  logic          pref_q, pref_d;          // FIFO to grant when both are non-empty
  logic          infl_q, infl_d;          // a popped word arrives this cycle
  logic          infl_src_q, infl_src_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic          err_q, err_d;

  logic          avail0_c, avail1_c;
  logic          serving_c, can_pop_c, hs_c;
  logic          pop0_c, pop1_c;
  logic          mismatch_c, idle_cond_c;
  logic [2:0]    occ_c, lim_c;
  tagged_word_t  cap_word_c;
  tagged_word_t  head_c;
  logic          buf_valid_c;
  logic [1:0]    buf_cnt;

  out_buf2 u_buf (
    .clk     (clk),
    .reset   (reset),
    .flush   (init),
    .wr_en   (infl_q),
    .wr_word (cap_word_c),
    .rd_en   (hs_c),
    .valid_c (buf_valid_c),
    .head_c  (head_c),
    .count   (buf_cnt)
  );

  // Capture path, credit and grant decode.
  always_comb begin
    avail0_c         = !bus.empty_d0;
    avail1_c         = !bus.empty_d1;
    cap_word_c.src   = infl_src_q;
    cap_word_c.data  = infl_src_q ? bus.data_d1 : bus.data_d0;
    mismatch_c       = infl_q && (cap_word_c.data[DEST_BIT] != infl_src_q);
    hs_c             = buf_valid_c && bus.ready_out;
    // Free space counting the word in flight and this cycle's dequeue.
    occ_c            = 3'(buf_cnt) + 3'(infl_q);
    lim_c            = 3'd2 + 3'(hs_c);
    can_pop_c        = (occ_c < lim_c);
    serving_c        = (state_q == ST_IDLE || state_q == ST_ACTIVE) && !init && !reset;
    pop0_c           = serving_c && can_pop_c && avail0_c && (!avail1_c || !pref_q);
    pop1_c           = serving_c && can_pop_c && avail1_c && (!avail0_c ||  pref_q);
    idle_cond_c      = !avail0_c && !avail1_c && !infl_q && (buf_cnt == 2'd0);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  if (init) state_d = ST_INIT;
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (init) state_d = ST_INIT;
                 else if (avail0_c || avail1_c) state_d = ST_ACTIVE;
      ST_ACTIVE: if (init) state_d = ST_INIT;
                 else if (idle_cond_c) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
  end

  // FSM / datapath outputs.
  always_comb begin
    bus.pop_d0     = pop0_c;
    bus.pop_d1     = pop1_c;
    bus.valid_out  = buf_valid_c;
    bus.data_out   = head_c.data;
    bus.src_out    = head_c.src;
    bus.cnt_d0     = cnt0_q;
    bus.cnt_d1     = cnt1_q;
    bus.idle_out   = (state_q == ST_IDLE);
    bus.active_out = (state_q == ST_ACTIVE);
    // A bad word flags in the cycle it arrives, then stays latched.
    bus.error_out  = err_q || mismatch_c;
  end

  // Next value of pointer, in-flight tracking, counters and error latch.
  always_comb begin
    pref_d     = pref_q;
    infl_d     = pop0_c || pop1_c;
    infl_src_d = pop1_c;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    err_d      = err_q;
    if (pop0_c) pref_d = 1'b1;
    if (pop1_c) pref_d = 1'b0;
    if (infl_q && !infl_src_q) cnt0_d = cnt0_q + CW'(1);
    if (infl_q &&  infl_src_q) cnt1_d = cnt1_q + CW'(1);
    if (mismatch_c) err_d = 1'b1;
    // Flush discards the arriving word and restarts with D0 preferred.
    if (init) begin
      pref_d     = 1'b0;
      infl_d     = 1'b0;
      infl_src_d = 1'b0;
      cnt0_d     = '0;
      cnt1_d     = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pref_q     <= 1'b0;
      infl_q     <= 1'b0;
      infl_src_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      pref_q     <= pref_d;
      infl_q     <= infl_d;
      infl_src_q <= infl_src_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_trans_drain_arbiter.sv
// Directed bench for trans_drain_arbiter: a per-cycle vector table for
// reset/init, single-FIFO and alternating service, plus hand sequences for
// backpressure, destination error and mid-operation flush. The FIFOs are
// modelled with queues whose read data appears the cycle after a pop.
module tb_trans_drain_arbiter;
  import trans_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic init;

  trans_drain_arbiter_if bus ();

  trans_drain_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, ini, rdy;
    logic          ld0;
    logic [DW-1:0] w0;
    logic          ld1;
    logic [DW-1:0] w1;
    logic          e_pop0, e_pop1, e_valid;
    logic [DW-1:0] e_data;
    logic          e_src, e_idle, e_active, e_err;
    logic [CW-1:0] e_cnt0, e_cnt1;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] got [$];

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input int rst, input int ini, input int rdy,
                              input int ld0, input int w0, input int ld1, input int w1,
                              input int p0, input int p1, input int v, input int d,
                              input int s, input int idl, input int act, input int err,
                              input int c0, input int c1);
    vec_t r;
    r.rst = rst[0];  r.ini = ini[0];  r.rdy = rdy[0];
    r.ld0 = ld0[0];  r.w0  = DW'(w0);
    r.ld1 = ld1[0];  r.w1  = DW'(w1);
    r.e_pop0 = p0[0]; r.e_pop1 = p1[0]; r.e_valid = v[0];
    r.e_data = DW'(d); r.e_src = s[0];
    r.e_idle = idl[0]; r.e_active = act[0]; r.e_err = err[0];
    r.e_cnt0 = CW'(c0); r.e_cnt1 = CW'(c1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load0(input logic [DW-1:0] w);
    q0.push_back(w);
    bus.empty_d0 = 1'b0;
  endtask

  task automatic load1(input logic [DW-1:0] w);
    q1.push_back(w);
    bus.empty_d1 = 1'b0;
  endtask

  // Let inputs settle after the falling edge, record handshakes.
  task automatic sample();
    #1;
    if (bus.valid_out && bus.ready_out) got.push_back(bus.data_out);
  endtask

  // Cross the rising edge; popped FIFOs present their word just after it.
  task automatic advance();
    logic p0, p1;
    p0 = bus.pop_d0;
    p1 = bus.pop_d1;
    chk("pop_excl", 32'(p0 & p1), 32'd0);
    if (p0) chk("d0_underflow", 32'(q0.size() == 0), 32'd0);
    if (p1) chk("d1_underflow", 32'(q1.size() == 0), 32'd0);
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) bus.data_d0 = q0.pop_front();
    if (p1 && q1.size() > 0) bus.data_d1 = q1.pop_front();
    bus.empty_d0 = (q0.size() == 0);
    bus.empty_d1 = (q1.size() == 0);
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_init();
    init = 1'b1;
    step();
    init = 1'b0;
    sample();
    chk("init_flags", 32'({bus.idle_out, bus.active_out, bus.error_out,
                           bus.valid_out, bus.pop_d0, bus.pop_d1}), 32'd0);
    chk("init_cnt", 32'({bus.cnt_d0, bus.cnt_d1}), 32'd0);
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int npops;
    logic [DW-1:0] exp_bp [4];

    reset         = 1'b1;
    init          = 1'b0;
    bus.ready_out = 1'b1;
    bus.empty_d0  = 1'b1;
    bus.empty_d1  = 1'b1;
    bus.data_d0   = '0;
    bus.data_d1   = '0;

    //            rst ini rdy ld0 w0    ld1 w1    p0 p1 v  data  s  idl act err c0 c1
    vecs[0]  = mk(1,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 0,  0,  0,  0, 0);
    vecs[1]  = mk(0,  1,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 0,  0,  0,  0, 0);
    vecs[2]  = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 0,  0,  0,  0, 0);
    vecs[3]  = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 1,  0,  0,  0, 0);
    vecs[4]  = mk(0,  0,  1,  1,  'h00, 0,  0,    1, 0, 0, 0,    0, 1,  0,  0,  0, 0);
    vecs[5]  = mk(0,  0,  1,  1,  'h22, 0,  0,    1, 0, 1, 'h00, 0, 0,  1,  0,  0, 0);
    vecs[6]  = mk(0,  0,  1,  1,  'h04, 0,  0,    1, 0, 1, 'h22, 0, 0,  1,  0,  1, 0);
    vecs[7]  = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 1, 'h04, 0, 0,  1,  0,  2, 0);
    vecs[8]  = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 0,  1,  0,  3, 0);
    vecs[9]  = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 1,  0,  0,  3, 0);
    vecs[10] = mk(0,  1,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 1,  0,  0,  3, 0);
    vecs[11] = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 0,  0,  0,  0, 0);
    vecs[12] = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 1,  0,  0,  0, 0);
    vecs[13] = mk(0,  0,  1,  1,  'h00, 1,  'h11, 1, 0, 0, 0,    0, 1,  0,  0,  0, 0);
    vecs[14] = mk(0,  0,  1,  1,  'h04, 0,  0,    0, 1, 1, 'h00, 0, 0,  1,  0,  0, 0);
    vecs[15] = mk(0,  0,  1,  0,  0,    1,  'h15, 1, 0, 1, 'h11, 1, 0,  1,  0,  1, 0);
    vecs[16] = mk(0,  0,  1,  0,  0,    0,  0,    0, 1, 1, 'h04, 0, 0,  1,  0,  1, 1);
    vecs[17] = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 1, 'h15, 1, 0,  1,  0,  2, 1);
    vecs[18] = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 0,  1,  0,  2, 2);
    vecs[19] = mk(0,  0,  1,  0,  0,    0,  0,    0, 0, 0, 0,    0, 1,  0,  0,  2, 2);

    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      reset         = vecs[i].rst;
      init          = vecs[i].ini;
      bus.ready_out = vecs[i].rdy;
      if (vecs[i].ld0) load0(vecs[i].w0);
      if (vecs[i].ld1) load1(vecs[i].w1);
      sample();
      chk($sformatf("vec%0d_pops", i), 32'({bus.pop_d0, bus.pop_d1}),
          32'({vecs[i].e_pop0, vecs[i].e_pop1}));
      chk($sformatf("vec%0d_valid", i), 32'(bus.valid_out), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_word", i), 32'({bus.src_out, bus.data_out}),
            32'({vecs[i].e_src, vecs[i].e_data}));
      chk($sformatf("vec%0d_flags", i), 32'({bus.idle_out, bus.active_out, bus.error_out}),
          32'({vecs[i].e_idle, vecs[i].e_active, vecs[i].e_err}));
      chk($sformatf("vec%0d_cnt", i), 32'({bus.cnt_d0, bus.cnt_d1}),
          32'({vecs[i].e_cnt0, vecs[i].e_cnt1}));
      advance();
    end
    reset = 1'b0;
    init  = 1'b0;

    // Backpressure: D1 holds 4 words, sink stalls for 5 cycles.
    do_init();
    bus.ready_out = 1'b0;
    exp_bp = '{6'h10, 6'h12, 6'h14, 6'h16};
    for (int i = 0; i < 4; i++) load1(exp_bp[i]);
    got.delete();
    npops = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      npops += 32'(bus.pop_d0) + 32'(bus.pop_d1);
      if (i > 0)
        chk($sformatf("bp_hold%0d", i), 32'({bus.valid_out, bus.src_out, bus.data_out}),
            32'({1'b1, 1'b1, 6'h10}));
      advance();
    end
    chk("bp_pops", 32'(npops), 32'd2);
    bus.ready_out = 1'b1;
    repeat (8) step();
    sample();
    chk("bp_cnt_d1", 32'(bus.cnt_d1), 32'd4);
    chk("bp_len", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("bp_word%0d", i), 32'(got[i]), 32'(exp_bp[i]));
    advance();

    // Destination error: D0 supplies a word tagged for D1.
    do_init();
    bus.ready_out = 1'b1;
    load0(6'h31);
    sample();
    chk("err_pop", 32'({bus.pop_d0, bus.error_out}), 32'b10);
    advance();
    sample();
    chk("err_rise", 32'(bus.error_out), 32'd1);
    chk("err_word", 32'({bus.valid_out, bus.src_out, bus.data_out}), 32'({1'b1, 1'b0, 6'h31}));
    advance();
    repeat (3) step();
    sample();
    chk("err_sticky", 32'({bus.error_out, bus.idle_out}), 32'b11);
    advance();
    do_init();
    sample();
    chk("err_clear", 32'(bus.error_out), 32'd0);
    advance();

    // Flush with one word buffered and one in flight.
    do_init();
    bus.ready_out = 1'b0;
    load0(6'h02);
    load0(6'h06);
    load0(6'h08);
    sample();
    chk("fl_popA", 32'({bus.pop_d0, bus.pop_d1}), 32'b10);
    advance();
    sample();
    chk("fl_popB", 32'({bus.pop_d0, bus.pop_d1}), 32'b10);
    chk("fl_headB", 32'({bus.valid_out, bus.data_out}), 32'({1'b1, 6'h02}));
    advance();
    init = 1'b1;
    load1(6'h13);
    sample();
    chk("fl_preC", 32'({bus.valid_out, bus.data_out, bus.cnt_d0}), 32'({1'b1, 6'h02, 8'd1}));
    chk("fl_nopopC", 32'({bus.pop_d0, bus.pop_d1}), 32'd0);
    advance();
    init = 1'b0;
    sample();
    chk("fl_initD", 32'({bus.valid_out, bus.pop_d0, bus.pop_d1, bus.idle_out, bus.active_out}), 32'd0);
    chk("fl_cntD", 32'({bus.cnt_d0, bus.cnt_d1}), 32'd0);
    advance();
    bus.ready_out = 1'b1;
    got.delete();
    sample();
    chk("fl_pref", 32'({bus.pop_d0, bus.pop_d1, bus.idle_out}), 32'b101);
    advance();
    repeat (6) step();
    chk("fl_len", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("fl_word0", 32'(got[0]), 32'h08);
      chk("fl_word1", 32'(got[1]), 32'h13);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trans_drain_arbiter.md
# trans_drain_arbiter

Read-side counterpart of the transaction layer. It drains the two destination FIFOs (D0, D1) by generating `pop_d0`/`pop_d1` and merges their 6-bit words into one valid/ready output stream. Service is round-robin and back-to-back capable. The block checks each word's destination bit against its source FIFO, keeps per-FIFO drain counts, and reports idle/active/error status the same way the transaction layer does.

## Interface
- `DW`, 6: data word width
- `DEST_BIT`, 4: bit of the word that names its destination FIFO (0 → D0, 1 → D1)
- `CW`, 8: width of the per-FIFO drain counters
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `init` in 1: one-cycle pulse; flushes the block and enters service
- `empty_d0`, `empty_d1` in 1: destination FIFO empty flags
- `data_d0`, `data_d1` in DW: FIFO read data, valid the cycle after the matching pop
- `ready_out` in 1: downstream accepts `data_out` this cycle
- `pop_d0`, `pop_d1` out 1: FIFO read strobes, never both high
- `data_out` out DW: merged word
- `valid_out` out 1: `data_out` is valid
- `src_out` out 1: source FIFO of `data_out`
- `cnt_d0`, `cnt_d1` out CW: words drained per FIFO since the last init
- `active_out`, `idle_out`, `error_out` out 1: status flags

## Operation
- States:
  - RESET: entered while `reset` is high; stays here until `init`.
  - INIT: one cycle. Clears counters, `error_out`, the output buffer, the in-flight word and the round-robin pointer, which is set to prefer D0.
  - IDLE: both FIFOs empty, nothing in flight, buffer empty.
  - ACTIVE: otherwise.
- State transitions:
  - RESET→INIT on `init`.
  - INIT→IDLE unconditionally.
  - IDLE→ACTIVE when either empty flag is 0.
  - ACTIVE→IDLE when the IDLE condition holds.
  - `init` in IDLE or ACTIVE re-enters INIT. Any in-flight word is discarded; that loss is accepted.
- Output buffer: 2-entry FIFO.
  - `credit = 2 − count − inflight + (valid_out & ready_out)`.
  - A pop issues only in IDLE/ACTIVE with credit ≥ 1.
- Grant:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the FIFO not granted last is granted.
  - `pop_dk` is combinational from registered state and the empty flags.
- Capture: the cycle after `pop_dk`, `data_dk` is written to the buffer with tag k.
  - `cnt_dk` increments and wraps modulo 2^CW.
  - If `data[DEST_BIT] != k`, `error_out` is set and stays set until INIT or reset. The word is still forwarded.
- Output: the buffer head drives `data_out`/`src_out`/`valid_out`. It pops on `valid_out & ready_out`.
  - `data_out` and `src_out` hold while `valid_out & !ready_out`.
- Status flags: `idle_out` = state IDLE. `active_out` = state ACTIVE.

## Timing
- Reset values: all outputs 0; state RESET.
- Latency: pop at cycle t → `valid_out` at t+1 (buffer empty case, write-through to head).
- Throughput: 1 word/cycle sustained while `ready_out` = 1 and a FIFO is non-empty.
- Backpressure: with `ready_out` = 0, pops stop once `count + inflight` = 2. No word is dropped or reordered.
- Simultaneous events within one cycle are all applied: enqueue of the in-flight word, dequeue on the handshake, and a new pop.
- `reset` has priority over `init`. `init` has priority over pops; no pop is issued in the INIT cycle.
- Empty flags are sampled the same cycle as the pop. The FIFO guarantees `empty = 0` means one readable word.

## Structure
- Shared package `trans_pkg`:
  - `DW`, `DEST_BIT`
  - state enum {RESET, INIT, IDLE, ACTIVE}
  - tagged-word type {src, data}
- Sub-module `out_buf2`: 2-entry FIFO with count output, flush input, and write-through to head.
- Top level: FSM, grant logic, in-flight register, counters, error check.

## Test plan
- **Reset/init:** hold `reset` 2 cycles, then pulse `init` → all outputs 0, `idle_out` = 1 the cycle after INIT, no pop.
- **D0 alone:** D0 holds 0x00, 0x22, 0x04 (bit 4 = 0), `ready_out` = 1 → `pop_d0` on 3 consecutive cycles, `valid_out` 3 consecutive cycles starting the cycle after the first pop, same order, `src_out` = 0, `cnt_d0` = 3, `error_out` = 0.
- **Both FIFOs:** D0 = {0x00, 0x04}, D1 = {0x11, 0x15} → pop order D0, D1, D0, D1; `data_out` 0x00, 0x11, 0x04, 0x15.
- **Backpressure:** D1 holds 4 words, `ready_out` = 0 for 5 cycles → exactly 2 pops, `data_out` held stable; on release all 4 delivered in order, `cnt_d1` = 4.
- **Error:** D0 supplies 0x31 (bit 4 = 1) → `error_out` rises the cycle after the pop, word still delivered, `error_out` stays 1 until the next `init`.
- **Mid-operation flush:** pulse `init` while 1 word is buffered and 1 is in flight → buffer cleared, counters 0, `valid_out` = 0 next cycle, service resumes preferring D0.
